i2c_master_ctrl: RTL and testbench
==================================

# i2c_master_ctrl

Synthesizable single-master I2C write controller that sequences transactions into the team's I2C slave. It runs from the system clock and takes an 8-bit address command plus a byte stream from a requester. It generates START, the address byte, the data bytes, ACK checks and STOP on an open-drain SDA and a push-pull SCL. Bit order is LSB-first, which matches the slave's right-shift receiver.

## Interface
- CLK_DIV, 250: system clocks per SCL quarter-period. SCL period = 4·CLK_DIV (100 kHz at 100 MHz). Legal values are ≥2.
- CLK  in  1: system clock, rising-edge.
- RST  in  1: asynchronous, active-high reset.
- CMD_VALID  in  1: start-transaction request.
- CMD_ADDR  in  8: full 8-bit address byte, sent as-is (slave default 8'h33).
- CMD_READY  out  1: high in IDLE only; the command is accepted when CMD_VALID and CMD_READY are both high.
- TX_DATA  in  8: next data byte.
- TX_LAST  in  1: marks the final byte of the transaction.
- TX_VALID  in  1: byte available.
- TX_READY  out  1: high only in LOAD; the byte is taken on a cycle where TX_VALID and TX_READY are both high.
- BUSY  out  1: high from command acceptance until the end of bus-free time.
- DONE  out  1: one-cycle pulse when STOP completes.
- NACK_ERR  out  1: one-cycle pulse, coincident with DONE, when any ACK slot read high.
- SCL  out  1: I2C clock, push-pull. No clock stretching is supported.
- SDA  inout  1: open-drain. The block drives 0 or Z only.

## Operation
- A prescaler produces a one-cycle quarter tick (qtick) every CLK_DIV clocks. All bus activity advances on qtick. The 2-bit phase counter q0..q3 runs per bit slot:
  - q0/q1: SCL low. SDA changes at q0.
  - q2/q3: SCL high. SDA is sampled at the start of q3.
- States and transitions:
  - IDLE → START on command accept. CMD_ADDR is latched into the shift register.
  - START: SDA released and SCL high for 2 quarters, then SDA low, hold 2 quarters, then SCL low → ADDR.
  - ADDR / DATA: 8 bit slots, bit[0] first. A bit counter 0..7 shifts the register right.
  - ADDR_ACK / DATA_ACK: SDA released for 1 bit slot and sampled at q3. A low sample is ACK.
    - NACK → STOP.
    - ACK after ADDR → LOAD.
    - ACK after DATA: → STOP if the latched last flag is set, otherwise → LOAD.
  - LOAD: SCL held low, SDA held low. Waits indefinitely for TX_VALID. On the handshake, latch TX_DATA and TX_LAST → DATA at the next qtick.
  - STOP: SDA low with SCL low for 1 quarter, SCL high for 1 quarter, SDA released, hold 1 quarter. Pulse DONE (and NACK_ERR if flagged) → GAP.
  - GAP: bus free for 4 quarters → IDLE.
- NACK_ERR is sticky within a transaction and cleared on the next command accept.
- Bytes not yet consumed when a NACK occurs are left untouched. The requester flushes them.
- SDA is never changed while SCL is high, except for START and STOP.

## Timing
- Reset values: SCL=1, SDA=Z, CMD_READY=1 (after reset is released), TX_READY=0, BUSY=0, DONE=0, NACK_ERR=0. State=IDLE and the prescaler is cleared.
- RST mid-transfer: the bus is released immediately (SDA=Z, SCL=1). No STOP is generated and no DONE pulse occurs.
- Bus latency from command accept to SDA falling edge: 2 quarters plus up to one prescaler period.
- One byte plus ACK = 9 bit slots = 36 quarters.
- LOAD, when data is already valid, costs exactly 1 quarter.
- CMD_VALID held during BUSY is ignored and stays pending. It is not lost.
- Simultaneous TX_VALID and NACK detection: NACK wins and TX_READY stays low.
- TX_LAST on the first byte gives a single-byte transfer.
- A zero-byte transfer is not supported. Every command sends at least one data byte.

## Structure
- Shared package i2c_pkg contains:
  - the state encoding (IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP, GAP)
  - the phase constants q0–q3
  - the slave address constant 8'h33
- Sub-module i2c_qtick: parameterized CLK_DIV prescaler with a clear input, producing qtick.
- Top level contains the FSM, the bit counter, the shift register and the open-drain SDA assign.

## Test plan
All scenarios use CLK_DIV=4 with the team slave model attached.
- Address and single byte: CMD 8'h33, TX 8'hA5 with LAST. Required response:
  - SDA bits 1,1,0,0,1,1,0,0 then ACK.
  - Then 1,0,1,0,0,1,0,1 then ACK, then STOP.
  - Slave Data_OUT=8'hA5. DONE=1, NACK_ERR=0.
- Wrong address: CMD 8'h34. Required response: ACK slot reads high, STOP is issued, DONE and NACK_ERR pulse together, TX_READY is never asserted.
- Multi-byte with stall: bytes 8'h01, 8'h02, 8'hFF (LAST), with TX_VALID withheld 50 clocks before the second byte. Required response:
  - SCL is held low during the stall.
  - Slave outputs 1, 2, 255 in order.
  - Exactly one STOP.
- Back-to-back commands: CMD_VALID held high across two transactions. Required response: second START begins no earlier than 16 clocks after STOP completes, and BUSY stays continuous.
- Reset mid-byte: assert RST at bit 3 of the data byte. Required response: within 1 clock SDA=Z and SCL=1. DONE stays 0, and CMD_READY=1 after RST is released.
- Bus protocol monitor in all scenarios: no SDA edge while SCL is high other than START and STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding, phase constants and bus-level helpers for the I2C master
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    LOAD,
    DATA,
    DATA_ACK,
    STOP,
    GAP
  } state_t;

  // Quarter phases of one bit slot: q0/q1 SCL low, q2/q3 SCL high.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [7:0] SLAVE_ADDR = 8'h33;

  // SCL level for a given state and quarter phase.
  function automatic logic scl_level(input state_t st, input logic [1:0] ph);
    logic lvl;
    lvl = 1'b1;
    case (st)
      ADDR, ADDR_ACK, DATA, DATA_ACK: lvl = ph[1];
      LOAD:                           lvl = 1'b0;
      STOP:                           lvl = (ph != Q0);
      default:                        lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  // High when the master must pull SDA low; ACK slots and idle time release the line.
  function automatic logic sda_pull_low(input state_t st, input logic [1:0] ph, input logic bit0);
    logic low;
    low = 1'b0;
    case (st)
      START:      low = ph[1];
      ADDR, DATA: low = ~bit0;
      LOAD:       low = 1'b1;
      STOP:       low = ~ph[1];
      default:    low = 1'b0;
    endcase
    return low;
  endfunction

endpackage

// File: rtl/i2c_master_ctrl_qtick.sv
// rtl/i2c_master_ctrl_qtick.sv - quarter-period prescaler for the I2C master
// Ports:
//   CLK, RST : system clock, asynchronous active-high reset
//   clear    : holds the divider at zero so the first quarter after release is full length
//   qtick    : one-cycle pulse every CLK_DIV clocks while not cleared
module i2c_qtick #(
  parameter int CLK_DIV = 250
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic qtick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign qtick = ~clear & (cnt == LAST);

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-master I2C write controller (START, address, data bytes, ACK checks, STOP)
// Ports:
//   CLK, RST                       : system clock, asynchronous active-high reset
//   CMD_VALID/CMD_READY, CMD_ADDR  : command handshake and the 8-bit address byte sent as-is
//   TX_DATA/TX_LAST/TX_VALID/TX_READY : byte stream, TX_LAST marks the final byte
//   BUSY                           : command accepted and bus-free time not yet elapsed
//   DONE, NACK_ERR                 : one-cycle pulses when STOP completes
//   SCL                            : push-pull clock; SDA : open-drain data (0 or Z)
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  input  logic [7:0] CMD_ADDR,
  output logic       CMD_READY,
  input  logic [7:0] TX_DATA,
  input  logic       TX_LAST,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       BUSY,
  output logic       DONE,
  output logic       NACK_ERR,
  output logic       SCL,
  inout  wire        SDA
);

  state_t     state, state_nxt;
  logic [1:0] phase, phase_nxt;
  logic [2:0] bitcnt, bitcnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       last_q, last_nxt;
  logic       loaded, loaded_nxt;
  logic       nack_q, nack_nxt;
  logic       ack_q, ack_nxt;
  logic       done_nxt, nerr_nxt;
  logic       scl_q, sda_low_q;
  logic       qtick;

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .CLK   (CLK),
    .RST   (RST),
    .clear (state == IDLE),
    .qtick (qtick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      phase     <= Q0;
      bitcnt    <= '0;
      shreg     <= '0;
      last_q    <= 1'b0;
      loaded    <= 1'b0;
      nack_q    <= 1'b0;
      ack_q     <= 1'b0;
      DONE      <= 1'b0;
      NACK_ERR  <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      bitcnt    <= bitcnt_nxt;
      shreg     <= shreg_nxt;
      last_q    <= last_nxt;
      loaded    <= loaded_nxt;
      nack_q    <= nack_nxt;
      ack_q     <= ack_nxt;
      DONE      <= done_nxt;
      NACK_ERR  <= nerr_nxt;
      // Bus pins are registered from the next state so they never glitch on state decode.
      scl_q     <= scl_level(state_nxt, phase_nxt);
      sda_low_q <= sda_pull_low(state_nxt, phase_nxt, shreg_nxt[0]);
    end
  end

  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    last_nxt   = last_q;
    loaded_nxt = loaded;
    nack_nxt   = nack_q;
    ack_nxt    = ack_q;
    done_nxt   = 1'b0;
    nerr_nxt   = 1'b0;

    if (qtick && state != IDLE && state != LOAD) begin
      phase_nxt = phase + 2'd1;
    end

    case (state)
      IDLE: begin
        if (CMD_VALID) begin
          state_nxt  = START;
          shreg_nxt  = CMD_ADDR;
          phase_nxt  = Q0;
          bitcnt_nxt = '0;
          nack_nxt   = 1'b0;
        end
      end
      START: begin
        if (qtick && phase == Q3) state_nxt = ADDR;
      end
      ADDR, DATA: begin
        // New bit appears on the same edge SCL falls (start of q0).
        if (qtick && phase == Q3) begin
          shreg_nxt  = {1'b0, shreg[7:1]};
          bitcnt_nxt = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_nxt = (state == ADDR) ? ADDR_ACK : DATA_ACK;
        end
      end
      ADDR_ACK, DATA_ACK: begin
        if (qtick && phase == Q2) ack_nxt = SDA;
        if (qtick && phase == Q3) begin
          if (ack_q) begin
            nack_nxt  = 1'b1;
            state_nxt = STOP;
          end else if (state == ADDR_ACK || !last_q) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = STOP;
          end
        end
      end
      LOAD: begin
        if (TX_VALID && !loaded) begin
          shreg_nxt  = TX_DATA;
          last_nxt   = TX_LAST;
          loaded_nxt = 1'b1;
        end
        if (qtick && loaded) begin
          state_nxt  = DATA;
          phase_nxt  = Q0;
          bitcnt_nxt = '0;
          loaded_nxt = 1'b0;
        end
      end
      STOP: begin
        if (qtick && phase == Q2) begin
          state_nxt = GAP;
          phase_nxt = Q0;
          done_nxt  = 1'b1;
          nerr_nxt  = nack_q;
        end
      end
      GAP: begin
        if (qtick && phase == Q3) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign CMD_READY = (state == IDLE);
  assign TX_READY  = (state == LOAD) & ~loaded;
  // The accept cycle itself counts as busy, so a held CMD_VALID keeps BUSY unbroken.
  assign BUSY      = (state != IDLE) | CMD_VALID;
  assign SCL       = scl_q;
  assign SDA       = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - self-checking bench for i2c_master_ctrl with a behavioural slave and bus monitor
module tb_i2c_master_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic [7:0] CMD_ADDR = 8'h00;
  logic       CMD_READY;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_LAST = 1'b0;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic       BUSY;
  logic       DONE;
  logic       NACK_ERR;
  logic       SCL;
  wire        SDA;
  logic       slave_low = 1'b0;

  pullup (SDA);
  assign SDA = slave_low ? 1'b0 : 1'bz;

  i2c_master_ctrl #(.CLK_DIV(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_READY (CMD_READY),
    .TX_DATA   (TX_DATA),
    .TX_LAST   (TX_LAST),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .NACK_ERR  (NACK_ERR),
    .SCL       (SCL),
    .SDA       (SDA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Slave + protocol monitor: bits sampled on SCL rise, START/STOP as SDA edges under high SCL.
  bit         mon_pscl, mon_psda;
  int         mon_bitn;
  bit         mon_addr_phase, mon_addr_ok, mon_in_txn;
  logic [7:0] mon_sr;
  bit         mon_bits[$];
  logic [7:0] mon_rx[$];
  int         mon_starts = 0, mon_stops = 0, mon_viol = 0;
  time        mon_start_time = 0;

  always @(negedge CLK) begin
    bit s_scl, s_sda;
    if (RST) begin
      mon_in_txn = 0;
      slave_low  = 1'b0;
      mon_pscl   = 1;
      mon_psda   = 1;
      mon_bitn   = 0;
    end else begin
      s_scl = (SCL === 1'b1);
      s_sda = (SDA === 1'b0) ? 1'b0 : 1'b1;
      if (mon_pscl && s_scl && (mon_psda != s_sda)) begin
        if (!s_sda) begin
          if (mon_in_txn) mon_viol++;
          mon_in_txn = 1; mon_bitn = 0; mon_addr_phase = 1; mon_addr_ok = 0;
          mon_bits.delete(); mon_rx.delete();
          mon_starts++; mon_start_time = $time;
        end else begin
          // A STOP follows exactly one SCL rise after a byte boundary; that rise is not data.
          if (!mon_in_txn || mon_bitn != 1) mon_viol++;
          if (mon_bits.size() > 0) mon_bits.pop_back();
          mon_in_txn = 0; mon_bitn = 0; slave_low = 1'b0;
          mon_stops++;
        end
      end
      if (!mon_pscl && s_scl && mon_in_txn) begin
        mon_bits.push_back(s_sda);
        if (mon_bitn < 8) mon_sr = {s_sda, mon_sr[7:1]};
        mon_bitn++;
        if (mon_bitn == 8) begin
          if (mon_addr_phase) mon_addr_ok = (mon_sr == 8'h33);
          else if (mon_addr_ok) mon_rx.push_back(mon_sr);
        end
        if (mon_bitn == 9) begin
          mon_bitn = 0;
          mon_addr_phase = 0;
        end
      end
      if (mon_pscl && !s_scl && mon_in_txn) begin
        slave_low = (mon_bitn == 8) && mon_addr_ok;
      end
      mon_pscl = s_scl;
      mon_psda = s_sda;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [7:0] tx_bytes[8];
  int         tx_stall[8];
  int         tx_n;
  bit         r_done, r_nerr, r_txready, r_sclbad, r_busy_drop;
  int         r_taken;
  time        r_done_time;

  task automatic run_txn(input logic [7:0] addr, input bit keep_cmd);
    int cyc, idx, stall;
    bit take;
    cyc = 0; idx = 0; take = 0; stall = tx_stall[0];
    r_done = 0; r_nerr = 0; r_txready = 0; r_sclbad = 0; r_busy_drop = 0; r_taken = 0;
    CMD_ADDR = addr;
    CMD_VALID = 1'b1;
    while (!CMD_READY && cyc < 4000) begin
      if (!BUSY) r_busy_drop = 1;
      @(negedge CLK); cyc++;
    end
    @(negedge CLK);
    if (!keep_cmd) CMD_VALID = 1'b0;
    while (cyc < 4000) begin
      if (take) begin
        idx++; r_taken++; TX_VALID = 1'b0; take = 0;
        if (idx < tx_n) stall = tx_stall[idx];
      end
      if (!TX_VALID && idx < tx_n) begin
        if (stall > 0) stall--;
        else begin
          TX_VALID = 1'b1;
          TX_DATA  = tx_bytes[idx];
          TX_LAST  = (idx == tx_n - 1);
        end
      end
      if (TX_READY) begin
        r_txready = 1;
        if (SCL) r_sclbad = 1;
      end
      if (!BUSY) r_busy_drop = 1;
      if (DONE) begin
        r_done = 1; r_nerr = NACK_ERR; r_done_time = $time;
        break;
      end
      take = TX_VALID && TX_READY;
      @(negedge CLK); cyc++;
    end
    TX_VALID = 1'b0;
  endtask

  // Expected bus content: address LSB-first, ACK only for the slave's address, then each byte and an ACK.
  task automatic verify_txn(input string tag, input logic [7:0] addr, input int s0, input int p0);
    bit exp_bits[$];
    logic [7:0] b;
    bit ack;
    int mism, rxm;
    ack = (addr == 8'h33);
    for (int i = 0; i < 8; i++) exp_bits.push_back(addr[i]);
    exp_bits.push_back(!ack);
    if (ack) begin
      for (int k = 0; k < tx_n; k++) begin
        b = tx_bytes[k];
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        exp_bits.push_back(1'b0);
      end
    end
    mism = 0;
    if (mon_bits.size() != exp_bits.size()) mism = 1000 + mon_bits.size();
    else for (int i = 0; i < exp_bits.size(); i++) if (mon_bits[i] != exp_bits[i]) mism++;
    rxm = 0;
    if (mon_rx.size() != (ack ? tx_n : 0)) rxm = 1000 + mon_rx.size();
    else for (int i = 0; i < mon_rx.size(); i++) if (mon_rx[i] !== tx_bytes[i]) rxm++;
    check({tag, "_sda_bits_mismatches"}, mism, 0);
    check({tag, "_rx_bytes_mismatches"}, rxm, 0);
    check({tag, "_done"}, r_done, 1);
    check({tag, "_nack_err"}, r_nerr, !ack);
    check({tag, "_stop_count"}, mon_stops - p0, 1);
    check({tag, "_start_count"}, mon_starts - s0, 1);
    check({tag, "_tx_ready_seen"}, r_txready, ack);
    check({tag, "_bytes_taken"}, r_taken, ack ? tx_n : 0);
    check({tag, "_scl_high_in_load"}, r_sclbad, 0);
  endtask

  initial begin
    int s0, p0, cyc;
    bit tk, hit, done_seen, busy_any;
    time t1;
    logic [7:0] a;

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_scl", SCL, 1);
    check("reset_sda", (SDA === 1'b0) ? 0 : 1, 1);
    check("reset_tx_ready", TX_READY, 0);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_nack_err", NACK_ERR, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("reset_cmd_ready", CMD_READY, 1);

    // Address 0x33 and a single last byte
    tx_n = 1; tx_bytes[0] = 8'hA5; tx_stall[0] = 0;
    s0 = mon_starts; p0 = mon_stops;
    run_txn(8'h33, 0);
    verify_txn("single", 8'h33, s0, p0);
    @(negedge CLK);
    check("single_done_one_cycle", DONE, 0);
    check("single_nack_one_cycle", NACK_ERR, 0);

    // Wrong address: NACK, STOP, byte left untouched
    tx_n = 1; tx_bytes[0] = 8'h5A; tx_stall[0] = 0;
    s0 = mon_starts; p0 = mon_stops;
    run_txn(8'h34, 0);
    verify_txn("wrong_addr", 8'h34, s0, p0);

    // Multi-byte with a 50-clock stall before the second byte
    tx_n = 3;
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h02; tx_bytes[2] = 8'hFF;
    tx_stall[0] = 0; tx_stall[1] = 50; tx_stall[2] = 0;
    s0 = mon_starts; p0 = mon_stops;
    run_txn(8'h33, 0);
    verify_txn("stall", 8'h33, s0, p0);

    // Back-to-back with CMD_VALID held across both transactions
    tx_n = 2; tx_bytes[0] = 8'h3C; tx_bytes[1] = 8'hC3; tx_stall[0] = 0; tx_stall[1] = 0;
    s0 = mon_starts; p0 = mon_stops;
    run_txn(8'h33, 1);
    verify_txn("b2b_first", 8'h33, s0, p0);
    t1 = r_done_time;
    busy_any = r_busy_drop;
    s0 = mon_starts; p0 = mon_stops;
    run_txn(8'h33, 0);
    busy_any = busy_any | r_busy_drop;
    verify_txn("b2b_second", 8'h33, s0, p0);
    check("b2b_gap_at_least_16_clocks", ((mon_start_time - t1) >= 160) ? 1 : 0, 1);
    check("b2b_busy_drop", busy_any, 0);

    // Randomized transactions against the reference model
    for (int t = 0; t < 6; t++) begin
      a = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h33;
      tx_n = $urandom_range(1, 4);
      for (int k = 0; k < tx_n; k++) begin
        tx_bytes[k] = 8'($urandom);
        tx_stall[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      end
      s0 = mon_starts; p0 = mon_stops;
      run_txn(a, 0);
      verify_txn($sformatf("rand%0d", t), a, s0, p0);
    end

    // Reset during bit 3 of the data byte
    CMD_ADDR = 8'h33; CMD_VALID = 1'b1; cyc = 0;
    while (!CMD_READY && cyc < 100) begin @(negedge CLK); cyc++; end
    @(negedge CLK);
    CMD_VALID = 1'b0;
    TX_DATA = 8'hA5; TX_LAST = 1'b1; TX_VALID = 1'b1;
    tk = 0; hit = 0; cyc = 0;
    while (cyc < 2000) begin
      if (TX_VALID && TX_READY) tk = 1;
      else if (tk) TX_VALID = 1'b0;
      if (mon_in_txn && !mon_addr_phase && mon_bitn == 4) begin
        hit = 1;
        break;
      end
      @(negedge CLK); cyc++;
    end
    TX_VALID = 1'b0;
    check("rst_reached_bit3", hit, 1);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("rst_scl_released", SCL, 1);
    check("rst_sda_released", (SDA === 1'b0) ? 0 : 1, 1);
    done_seen = 0;
    repeat (5) begin @(negedge CLK); if (DONE) done_seen = 1; end
    RST = 1'b0;
    repeat (20) begin @(negedge CLK); if (DONE) done_seen = 1; end
    check("rst_no_done", done_seen, 0);
    check("rst_cmd_ready", CMD_READY, 1);
    check("rst_busy", BUSY, 0);

    check("protocol_violations", mon_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
